// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply/divide unit with fixed 33-edge latency.
// Shift-add multiply with sign-corrected top partial product; restoring divide on magnitudes.
`timescale 1ns/1ps

module multdiv_iter (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [5:0]  cnt;
    logic        last_step;

    // multiply datapath
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;

    // divide datapath; quo starts as the dividend magnitude and fills with quotient bits
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic        is_div;
    logic        neg_q;
    logic        div_zero;
    logic        div_ovf;

    // FSM control
    logic        load_mul;
    logic        load_div;
    logic        step_mul;
    logic        step_div;
    logic        finish;

    // combinational helpers
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        fits;
    logic [63:0] acc_next;
    logic [31:0] fin_result;
    logic        fin_exc;

    assign last_step = (cnt == 6'd31);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        if (ctrl_MULT) begin
            state_next = MUL;
        end else if (ctrl_DIV) begin
            state_next = DIV;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                MUL:     if (last_step) state_next = DONE;
                DIV:     if (last_step) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // ---------------- output / control logic ----------------
    // A start in DONE still completes the finished op; a start in MUL/DIV aborts it.
    always_comb begin
        load_mul = ctrl_MULT;
        load_div = ctrl_DIV && !ctrl_MULT;
        step_mul = 1'b0;
        step_div = 1'b0;
        finish   = 1'b0;
        case (state)
            MUL:     step_mul = !(ctrl_MULT || ctrl_DIV);
            DIV:     step_div = !(ctrl_MULT || ctrl_DIV);
            DONE:    finish   = 1'b1;
            default: ;
        endcase
    end

    // ---------------- arithmetic helpers ----------------
    always_comb begin
        a_mag   = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
        b_mag   = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;
        shifted = {rem, quo[31]};
        fits    = (shifted >= {1'b0, divisor});
        // true difference is below divisor, so the low 32 bits are exact
        diff    = shifted[31:0] - divisor;
    end

    // bit 31 of the multiplier carries weight -2^31, so its partial product is subtracted
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = last_step ? (acc - mcand) : (acc + mcand);
        end
    end

    always_comb begin
        fin_result = acc[31:0];
        fin_exc    = (acc[63:32] != {32{acc[31]}});
        if (is_div) begin
            if (div_zero) begin
                fin_result = 32'd0;
                fin_exc    = 1'b1;
            end else if (div_ovf) begin
                fin_result = 32'h8000_0000;
                fin_exc    = 1'b1;
            end else begin
                fin_result = neg_q ? (32'd0 - quo) : quo;
                fin_exc    = 1'b0;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (load_mul || load_div) begin
            cnt      <= '0;
            is_div   <= load_div;
            acc      <= '0;
            mcand    <= {{32{data_operandA[31]}}, data_operandA};
            mplier   <= data_operandB;
            rem      <= '0;
            quo      <= a_mag;
            divisor  <= b_mag;
            neg_q    <= data_operandA[31] ^ data_operandB[31];
            div_zero <= (data_operandB == 32'd0);
            div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        end else if (step_mul) begin
            cnt    <= cnt + 6'd1;
            acc    <= acc_next;
            mcand  <= {mcand[62:0], 1'b0};
            mplier <= {1'b0, mplier[31:1]};
        end else if (step_div) begin
            cnt <= cnt + 6'd1;
            if (fits) begin
                rem <= diff;
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= shifted[31:0];
                quo <= {quo[30:0], 1'b0};
            end
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= finish;
            if (finish) begin
                data_result    <= fin_result;
                data_exception <= fin_exc;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter: stimulus pushes expected results, a negedge monitor pops on ready.
// Checks result, exception, 33-edge latency, single-cycle ready, restart, and async reset.
`timescale 1ns/1ps

module tb_multdiv_iter;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    multdiv_iter dut (
        .clk            (clk),
        .clr            (clr),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int unsigned e0;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;
    logic        prev_rdy = 1'b0;

    always #5 clk = ~clk;

    // edges counted from 1; at the negedge following edge N, cyc == N
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (!clr && data_resultRDY) begin
            if (prev_rdy) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rdy_single_cycle: got ready high 2 cycles expected 1 at edge %0d", cyc);
            end
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_rdy: got ready at edge %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check32({e.name, " result"}, data_result, e.res);
                check1({e.name, " exception"}, data_exception, e.exc);
                check_int({e.name, " latency"}, cyc - e.e0, 33);
            end
        end
        prev_rdy = data_resultRDY;
    end

    // ---------------- stimulus helpers ----------------
    // called at a negedge; the start is sampled at the next posedge (E0)
    task automatic go(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                      output int unsigned e0);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        e0            = cyc + 1;
        @(negedge clk);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic push(input logic [31:0] res, input logic exc, input int unsigned e0,
                        input string name);
        exp_t e;
        e.res  = res;
        e.exc  = exc;
        e.e0   = e0;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int unsigned n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int unsigned k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        string       name;
    } vec_t;

    vec_t vecs[$] = '{
        '{1'b0, 32'd3,          32'hFFFF_FFF9, 32'hFFFF_FFEB, 1'b0, "mul_3_m7"},
        '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul_ovf_2p32"},
        '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul_m1_m1"},
        '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul_min_m1"},
        '{1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, "div_m100_7"},
        '{1'b1, 32'd100,       32'd10,        32'd10,        1'b0, "div_100_10"},
        '{1'b1, 32'd5,         32'd0,         32'd0,         1'b1, "div_by_zero"},
        '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_min_m1"},
        '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "div_max_m1"},
        '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div_m7_2"},
        '{1'b1, 32'd0,         32'd5,         32'd0,         1'b0, "div_0_5"}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned e0;
        int unsigned e1;

        clr           = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (2) @(negedge clk);
        check32("reset result", data_result, 32'd0);
        check1("reset exception", data_exception, 1'b0);
        check1("reset rdy", data_resultRDY, 1'b0);
        clr = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            go(!vecs[i].is_div, vecs[i].is_div, vecs[i].a, vecs[i].b, e0);
            push(vecs[i].res, vecs[i].exc, e0, vecs[i].name);
            drain(vecs[i].name);
        end

        // back-to-back: second start lands on the edge ending the first ready cycle
        go(1'b1, 1'b0, 32'd3, 32'hFFFF_FFF9, e0);
        push(32'hFFFF_FFEB, 1'b0, e0, "b2b_first");
        wait_until(e0 + 33);
        go(1'b0, 1'b1, 32'd100, 32'd10, e1);
        push(32'd10, 1'b0, e1, "b2b_second");
        check32("hold result after start", data_result, 32'hFFFF_FFEB);
        check1("hold exception after start", data_exception, 1'b0);
        drain("b2b");

        // restart: DIV at edge 10 of a running MULT aborts it
        go(1'b1, 1'b0, 32'd2, 32'd3, e0);
        wait_until(e0 + 9);
        go(1'b0, 1'b1, 32'd100, 32'd10, e1);
        push(32'd10, 1'b0, e1, "restart_div");
        drain("restart_div");

        // both starts high: multiply wins
        go(1'b1, 1'b1, 32'd6, 32'd7, e0);
        push(32'd42, 1'b0, e0, "both_high");
        drain("both_high");

        // async reset at iteration 15
        go(1'b1, 1'b0, 32'h0000_1234, 32'h0000_0010, e0);
        wait_until(e0 + 15);
        #2;
        clr = 1'b1;
        #1;
        check32("clr result", data_result, 32'd0);
        check1("clr exception", data_exception, 1'b0);
        check1("clr rdy", data_resultRDY, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        repeat (40) @(negedge clk);
        go(1'b1, 1'b0, 32'd4, 32'd5, e0);
        push(32'd20, 1'b0, e0, "post_clr_mul");
        drain("post_clr_mul");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
